// File: rtl/pb_pack.sv
// Shared widths, constants and types for the program-buffer instruction path.
package pb_pack;

  localparam int globalAddress_width = 64;
  localparam int data_width          = 32;
  localparam int IMEM_DEPTH          = 256;

  typedef logic [globalAddress_width-1:0] gaddr_t;
  typedef logic [data_width-1:0]          word_t;

  // addi x0, x0, 0
  localparam word_t NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HALT,
    ST_LOAD,
    ST_RELEASE
  } imem_ctrl_state_t;

  // Registered fetch response: valid plus the select that substitutes a NOP.
  typedef struct packed {
    logic vld;
    logic nop;
  } fetch_rsp_t;

  // Full-width compare so aliased high addresses never hit the RAM.
  function automatic logic addr_in_range(input gaddr_t addr, input int depth);
    return addr < gaddr_t'(depth);
  endfunction

endpackage

// File: rtl/pb_imem_ctrl_if.sv
// Loader, fetch and RAM-port signals of the instruction-memory controller.
interface pb_imem_ctrl_if
  import pb_pack::*;
#(
  parameter int MEM_DEPTH = IMEM_DEPTH
) ();

  localparam int AW = $clog2(MEM_DEPTH);

  logic          load_mode_i;
  logic          wr_valid_i;
  logic          wr_ready_o;
  gaddr_t        wr_addr_i;
  word_t         wr_data_i;
  logic          fetch_req_i;
  gaddr_t        fetch_addr_i;
  logic          fetch_gnt_o;
  logic          fetch_rvalid_o;
  word_t         fetch_rdata_o;
  logic          mem_en_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  word_t         mem_wdata_o;
  word_t         mem_rdata_i;
  logic          core_rst_o;
  logic [AW:0]   load_count_o;
  logic          err_o;

  modport slave (
    input  load_mode_i, wr_valid_i, wr_addr_i, wr_data_i,
           fetch_req_i, fetch_addr_i, mem_rdata_i,
    output wr_ready_o, fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o,
           mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
           core_rst_o, load_count_o, err_o
  );

  modport master (
    output load_mode_i, wr_valid_i, wr_addr_i, wr_data_i,
           fetch_req_i, fetch_addr_i, mem_rdata_i,
    input  wr_ready_o, fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o,
           mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
           core_rst_o, load_count_o, err_o
  );

endinterface

// File: rtl/pb_release_timer.sv
// Settle timer: done rises CYCLES-1 cycles after start (or after reset).
module pb_release_timer #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic done
);

  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LOAD_VAL = W'(CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               cnt <= LOAD_VAL;
    else if (start)        cnt <= LOAD_VAL;
    else if (cnt != '0)    cnt <= cnt - W'(1);
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/pb_imem_ctrl.sv
// Arbitrates the single instruction-RAM port between the JTAG program loader
// and core fetch, holding the core in reset while a program is loaded.
module pb_imem_ctrl
  import pb_pack::*;
#(
  parameter int MEM_DEPTH      = IMEM_DEPTH,
  parameter int RELEASE_CYCLES = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  pb_imem_ctrl_if.slave  bus
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] COUNT_MAX = CW'(MEM_DEPTH);

  imem_ctrl_state_t state, state_nxt;
  fetch_rsp_t       rsp_q;

  logic          rel_start, rel_done;
  logic          wr_fire, wr_in_range, fetch_in_range, fetch_gnt;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  word_t         mem_wdata;
  logic [CW-1:0] load_count;
  logic          err, core_rst;

  assign wr_in_range    = addr_in_range(bus.wr_addr_i, MEM_DEPTH);
  assign fetch_in_range = addr_in_range(bus.fetch_addr_i, MEM_DEPTH);

  // Timer only needs kicking on entry; the reset state is already counting.
  assign rel_start = (state != ST_RELEASE) && (state_nxt == ST_RELEASE);

  pb_release_timer #(
    .CYCLES (RELEASE_CYCLES)
  ) u_release_timer (
    .clk   (clk_i),
    .rst   (rst_i),
    .start (rel_start),
    .done  (rel_done)
  );

  always_comb begin
    state_nxt = state;
    fetch_gnt = 1'b0;
    wr_fire   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      ST_RUN: begin
        // Load request wins over a same-cycle fetch so HALT sees no new grant.
        fetch_gnt = bus.fetch_req_i & ~bus.load_mode_i;
        if (fetch_gnt && fetch_in_range) begin
          mem_en   = 1'b1;
          mem_addr = bus.fetch_addr_i[AW-1:0];
        end
        if (bus.load_mode_i) state_nxt = ST_HALT;
      end
      ST_HALT: state_nxt = ST_LOAD;
      ST_LOAD: begin
        wr_fire = bus.wr_valid_i;
        if (wr_fire && wr_in_range) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = bus.wr_addr_i[AW-1:0];
          mem_wdata = bus.wr_data_i;
        end
        if (!bus.load_mode_i) state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (bus.load_mode_i) state_nxt = ST_HALT;
        else if (rel_done)   state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RELEASE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_RELEASE;
      core_rst   <= 1'b1;
      rsp_q      <= '0;
      load_count <= '0;
      err        <= 1'b0;
    end else begin
      state     <= state_nxt;
      core_rst  <= (state_nxt != ST_RUN);
      rsp_q.vld <= fetch_gnt;
      rsp_q.nop <= fetch_gnt & ~fetch_in_range;
      if (state == ST_HALT) begin
        load_count <= '0;
        err        <= 1'b0;
      end else if (wr_fire) begin
        if (!wr_in_range)                err        <= 1'b1;
        else if (load_count != COUNT_MAX) load_count <= load_count + CW'(1);
      end
    end
  end

  assign bus.fetch_gnt_o    = fetch_gnt;
  assign bus.wr_ready_o     = (state == ST_LOAD);
  assign bus.mem_en_o       = mem_en;
  assign bus.mem_we_o       = mem_we;
  assign bus.mem_addr_o     = mem_addr;
  assign bus.mem_wdata_o    = mem_wdata;
  assign bus.fetch_rvalid_o = rsp_q.vld;
  assign bus.fetch_rdata_o  = !rsp_q.vld ? '0 :
                              rsp_q.nop  ? NOP_INSTR : bus.mem_rdata_i;
  assign bus.core_rst_o     = core_rst;
  assign bus.load_count_o   = load_count;
  assign bus.err_o          = err;

endmodule
